// File: rtl/rr_burst_arbiter_pkg.sv
// Shared types and default sizing for the round-robin burst arbiter.
package rr_burst_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_LEN_W   = 4;

endpackage

// File: rtl/rr_priority_picker.sv
// Round-robin search: first set request strictly after ptr, wrapping modulo N.
// The request vector is doubled so the rotate is a plain part-select.
module rr_priority_picker #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    winner,
  output logic [ID_W-1:0] idx,
  output logic            any
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int             start;
  int             pos;
  logic           found;

  // Rotate so bit 0 is the requester after ptr, then find-first and unrotate.
  always_comb begin
    dbl    = {req, req};
    start  = (int'(ptr) + 1) % N;
    rot    = dbl[start +: N];
    found  = 1'b0;
    pos    = 0;
    winner = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        pos   = (start + i) % N;
      end
    end
    idx = ID_W'(pos);
    any = |req;
    if (found) begin
      winner[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Burst-granular round-robin arbiter sharing one valid/ready beat stream.
// A grant is held until the last beat of the burst is accepted downstream.
module rr_burst_arbiter
  import rr_burst_arbiter_pkg::*;
#(
  parameter  int NUM_REQ = DEF_NUM_REQ,
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int LEN_W   = DEF_LEN_W,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*LEN_W-1:0]   req_len,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [NUM_REQ-1:0]         gnt,
  output logic                       out_valid,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_last,
  output logic [ID_W-1:0]            out_id,
  input  logic                       out_ready
);

  state_e             state, state_next;
  logic [NUM_REQ-1:0] gnt_next;
  logic [ID_W-1:0]    owner, owner_next;
  logic [ID_W-1:0]    ptr, ptr_next;
  logic [LEN_W-1:0]   cnt, cnt_next;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [ID_W-1:0]    pick_idx;
  logic               pick_any;
  logic               in_burst;
  logic               handshake;

  rr_priority_picker #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_picker (
    .req    (req),
    .ptr    (ptr),
    .winner (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign in_burst  = (state == BURST);
  assign handshake = out_valid & out_ready;

  // Downstream mux follows the owner combinationally; everything is quiet outside a burst.
  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    out_id    = '0;
    req_ready = '0;
    if (in_burst) begin
      out_valid        = req_valid[owner];
      out_data         = req_data[int'(owner)*DATA_W +: DATA_W];
      out_last         = (cnt == '0) & req_valid[owner];
      out_id           = owner;
      req_ready[owner] = out_ready;
    end
  end

  // Next-state: arbitrate in IDLE, count beats in BURST, release on the final handshake.
  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    owner_next = owner;
    ptr_next   = ptr;
    cnt_next   = cnt;
    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = BURST;
          gnt_next   = pick_onehot;
          owner_next = pick_idx;
          cnt_next   = req_len[int'(pick_idx)*LEN_W +: LEN_W];
        end
      end
      BURST: begin
        if (handshake) begin
          if (cnt == '0) begin
            state_next = IDLE;
            gnt_next   = '0;
            ptr_next   = owner;
          end else begin
            cnt_next = cnt - LEN_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  // State registers; reset points the search just before requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      ptr   <= ID_W'(NUM_REQ - 1);
      cnt   <= '0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      owner <= owner_next;
      ptr   <= ptr_next;
      cnt   <= cnt_next;
    end
  end

  gnt_onehot0_a : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  valid_in_burst_a : assert property (@(posedge clk) disable iff (rst) out_valid |-> (state == BURST));

endmodule

// File: tb/tb_rr_burst_arbiter.sv
// Self-checking bench: vector table plus directed corner sequences, beats checked via a scoreboard.
module tb_rr_burst_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int LEN_W   = 4;
  localparam int ID_W    = 2;

  logic                      clk = 1'b0;
  logic                      rst;
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*LEN_W-1:0]  req_len;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        gnt;
  logic                      out_valid;
  logic [DATA_W-1:0]         out_data;
  logic                      out_last;
  logic [ID_W-1:0]           out_id;
  logic                      out_ready;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic              last;
  } beat_t;

  typedef struct {
    logic [NUM_REQ-1:0] reqMask;
    int                 len;
    int                 owner;
  } vec_t;

  beat_t              sb[$];
  int                 beatIdx[NUM_REQ];
  int                 expIdx[NUM_REQ];
  logic [NUM_REQ-1:0] hsMask;
  int                 compared = 0;
  int                 mismatched = 0;
  vec_t               vecs[15];

  rr_burst_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_len   (req_len),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_id    (out_id),
    .out_ready (out_ready)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Hard stop in case a sequence wedges despite its own cycle budgets.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [DATA_W-1:0] dataFor(int r, int k);
    return (DATA_W'(r) << 24) | DATA_W'(k);
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic driveData();
    for (int r = 0; r < NUM_REQ; r++) begin
      req_data[r*DATA_W +: DATA_W] = dataFor(r, beatIdx[r]);
    end
  endtask

  task automatic applyStimulus(input logic [NUM_REQ-1:0] reqMask, input int lenAll);
    req = reqMask;
    for (int r = 0; r < NUM_REQ; r++) begin
      req_len[r*LEN_W +: LEN_W] = LEN_W'(lenAll);
    end
  endtask

  task automatic pushBurst(input int r, input int len);
    beat_t b;
    for (int k = 0; k <= len; k++) begin
      b.id   = ID_W'(r);
      b.data = dataFor(r, expIdx[r]);
      b.last = (k == len);
      sb.push_back(b);
      expIdx[r]++;
    end
  endtask

  task automatic sampleEdge();
    beat_t exp;
    @(negedge clk);
    checkOutput("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
    checkOutput("valid_without_gnt", 64'(out_valid && (gnt == '0)), 64'd0);
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL sb_underflow: got beat id=%0d data=%h, expected no beat", out_id, out_data);
      end else begin
        exp = sb.pop_front();
        checkOutput("beat", 64'({out_id, out_data, out_last}), 64'(exp));
      end
    end
    hsMask = req_ready & req_valid;
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    for (int r = 0; r < NUM_REQ; r++) begin
      if (hsMask[r]) beatIdx[r]++;
    end
    driveData();
  endtask

  task automatic drainBurst(input string name, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      sampleEdge();
      advance();
      n++;
    end
    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL %s_timeout: got %0d beats pending, expected 0", name, sb.size());
    end
  endtask

  task automatic applyReset();
    rst = 1'b1;
    applyStimulus('0, 0);
    out_ready = 1'b1;
    sb.delete();
    sampleEdge();
    checkOutput("reset_outputs", 64'({gnt, req_ready, out_valid, out_last, out_id, out_data}), 64'd0);
    advance();
    for (int r = 0; r < NUM_REQ; r++) expIdx[r] = beatIdx[r];
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req       = '0;
    req_len   = '0;
    req_valid = '1;
    out_ready = 1'b1;
    hsMask    = '0;
    for (int r = 0; r < NUM_REQ; r++) begin
      beatIdx[r] = 0;
      expIdx[r]  = 0;
    end
    driveData();
    #1;

    vecs[0]  = '{4'b1111, 0, 0};
    vecs[1]  = '{4'b1111, 0, 1};
    vecs[2]  = '{4'b1111, 0, 2};
    vecs[3]  = '{4'b1111, 0, 3};
    vecs[4]  = '{4'b1111, 0, 0};
    vecs[5]  = '{4'b0001, 1, 0};
    vecs[6]  = '{4'b0001, 0, 0};
    vecs[7]  = '{4'b1001, 2, 3};
    vecs[8]  = '{4'b1001, 0, 0};
    vecs[9]  = '{4'b0110, 1, 1};
    vecs[10] = '{4'b0110, 0, 2};
    vecs[11] = '{4'b1000, 15, 3};
    vecs[12] = '{4'b0101, 0, 0};
    vecs[13] = '{4'b0101, 0, 2};
    vecs[14] = '{4'b0011, 0, 0};

    $display("[TB] test 1: single 4-beat burst from requester 0");
    applyReset();
    applyStimulus(4'b0001, 3);
    pushBurst(0, 3);
    sampleEdge();
    checkOutput("t1_idle_gnt", 64'(gnt), 64'd0);
    advance();
    sampleEdge();
    checkOutput("t1_gnt", 64'(gnt), 64'b0001);
    checkOutput("t1_out_id", 64'(out_id), 64'd0);
    advance();
    applyStimulus('0, 3);
    drainBurst("t1", 8);
    sampleEdge();
    checkOutput("t1_back_idle", 64'({gnt, out_valid}), 64'd0);
    advance();

    $display("[TB] test 2: vector table of grant order and burst lengths");
    applyReset();
    for (int v = 0; v < 15; v++) begin
      applyStimulus(vecs[v].reqMask, vecs[v].len);
      pushBurst(vecs[v].owner, vecs[v].len);
      sampleEdge();
      checkOutput("vec_bubble", 64'(gnt), 64'd0);
      advance();
      sampleEdge();
      checkOutput("vec_gnt", 64'(gnt), 64'(1) << vecs[v].owner);
      advance();
      drainBurst("vec", vecs[v].len + 3);
    end
    applyStimulus('0, 0);

    $display("[TB] test 3: owner 2 len 8 with toggling out_ready");
    applyStimulus(4'b0100, 7);
    pushBurst(2, 7);
    sampleEdge();
    advance();
    applyStimulus('0, 7);
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      out_ready = (n % 2 == 1);
      sampleEdge();
      checkOutput("t3_req_ready", 64'(req_ready), out_ready ? 64'b0100 : 64'd0);
      checkOutput("t3_gnt", 64'(gnt), 64'b0100);
      advance();
    end
    out_ready = 1'b1;
    checkOutput("t3_all_beats", 64'(sb.size()), 64'd0);
    sampleEdge();
    checkOutput("t3_released", 64'({gnt, out_valid}), 64'd0);
    advance();

    $display("[TB] test 4: owner drops req mid-burst");
    applyReset();
    applyStimulus(4'b1010, 0);
    req_len[1*LEN_W +: LEN_W] = 4'd5;
    pushBurst(1, 5);
    pushBurst(3, 0);
    sampleEdge();
    advance();
    sampleEdge();
    checkOutput("t4_gnt", 64'(gnt), 64'b0010);
    advance();
    sampleEdge();
    advance();
    req = 4'b1000;
    for (int n = 0; n < 10 && sb.size() > 1; n++) begin
      sampleEdge();
      checkOutput("t4_gnt_held", 64'(gnt), 64'b0010);
      advance();
    end
    sampleEdge();
    checkOutput("t4_bubble", 64'(gnt), 64'd0);
    advance();
    sampleEdge();
    checkOutput("t4_next_gnt", 64'(gnt), 64'b1000);
    advance();
    req = '0;
    checkOutput("t4_sb_empty", 64'(sb.size()), 64'd0);

    $display("[TB] test 5: reset mid-burst");
    applyStimulus(4'b0100, 7);
    pushBurst(2, 7);
    sampleEdge();
    advance();
    req = 4'b0110;
    for (int n = 0; n < 3; n++) begin
      sampleEdge();
      advance();
    end
    checkOutput("t5_beats_done", 64'(beatIdx[2] - (expIdx[2] - 8)), 64'd3);
    rst = 1'b1;
    #1;
    checkOutput("t5_async_outputs", 64'({gnt, req_ready, out_valid, out_last, out_id, out_data}), 64'd0);
    sb.delete();
    for (int r = 0; r < NUM_REQ; r++) expIdx[r] = beatIdx[r];
    sampleEdge();
    advance();
    sampleEdge();
    advance();
    rst = 1'b0;
    applyStimulus(4'b0110, 0);
    pushBurst(1, 0);
    sampleEdge();
    checkOutput("t5_idle_after_reset", 64'(gnt), 64'd0);
    advance();
    sampleEdge();
    checkOutput("t5_first_gnt", 64'(gnt), 64'b0010);
    advance();
    req = '0;
    drainBurst("t5", 4);
    sampleEdge();
    checkOutput("t5_released", 64'(gnt), 64'd0);
    advance();

    $display("[TB] test 6: req_len change after grant is ignored");
    applyStimulus(4'b0001, 2);
    pushBurst(0, 2);
    sampleEdge();
    advance();
    applyStimulus('0, 9);
    drainBurst("t6", 6);
    sampleEdge();
    checkOutput("t6_ended", 64'({gnt, out_valid}), 64'd0);
    advance();

    checkOutput("final_sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rr_burst_arbiter.md
Name: rr_burst_arbiter

Overview:
Shares one downstream valid/ready beat stream between NUM_REQ requesters. Grants are round-robin at burst granularity, and the grant is held until the final beat of the burst is accepted. The block is the DUT-side resource scheduler that the tb environment drives: requester agents on the input side and a sink agent on the output side. Bursts are never interleaved.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 32, beat data width
LEN_W, 4, burst length field width; field encodes beats-1, so max burst = 2**LEN_W beats
ID_W, $clog2(NUM_REQ), width of out_id (localparam, not overridable)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester burst request, level
req_len  in  NUM_REQ*LEN_W  per-requester beats-1; sampled only in the grant cycle
req_valid  in  NUM_REQ  per-requester beat valid
req_data  in  NUM_REQ*DATA_W  per-requester beat data
req_ready  out  NUM_REQ  per-requester beat ready
gnt  out  NUM_REQ  one-hot grant, registered
out_valid  out  1  downstream beat valid
out_data  out  DATA_W  downstream beat data
out_last  out  1  final beat of the burst
out_id  out  ID_W  index of the granted requester
out_ready  in  1  downstream ready

Behaviour:
- Reset (async assert, sync-style deassert at clock edge):
  - state=IDLE, gnt=0, beat counter=0, owner=0.
  - Round-robin pointer=NUM_REQ-1, so the first search starts at requester 0.
  - All outputs 0 while in reset and in IDLE.
- FSM states: IDLE, BURST.
- IDLE:
  - If |req, pick the winner as the first set req bit searching from pointer+1 upward, with wrap-around modulo NUM_REQ.
  - At the next edge: gnt[winner]=1, owner=winner, cnt=req_len[winner], state=BURST.
  - Request-to-grant latency is 1 cycle. If req is all-zero, stay in IDLE.
- BURST (datapath is combinational from the owner; no added latency):
  - out_valid=req_valid[owner], out_data=req_data[owner], out_id=owner.
  - req_ready[owner]=out_ready; all other req_ready=0.
  - out_last=(cnt==0) & out_valid.
  - A handshake is out_valid & out_ready. Each handshake with cnt!=0 decrements cnt.
  - A handshake with cnt==0 ends the burst at that edge: gnt=0, pointer=owner, state=IDLE.
  - Result: there is exactly one IDLE bubble cycle between consecutive bursts.
- Outside BURST: out_data=0, out_id=0, out_valid=0, out_last=0. All req_ready=0 in IDLE.
- Stalls: out_ready=0 or req_valid=0 holds cnt and grant indefinitely. There is no timeout.
- Owner deasserting req mid-burst is ignored; the grant persists until the last beat.
- Non-owner req/req_valid/req_data have no effect during BURST.
- req_len changes after the grant cycle are ignored.
- Single requester continuously requesting: it is re-granted every burst, with a 1-cycle bubble each time.
- All requesters requesting: grant order is pointer+1, pointer+2, ... (strict rotation, each requester at most one burst per round).
- Reset asserted mid-burst: the burst is abandoned immediately (async) and the partial burst is not completed after release. The first arbitration after reset favours requester 0.
- Assertions (bench + RTL):
  - gnt is one-hot or zero.
  - out_valid implies state==BURST.
  - Exactly cnt+1 handshakes occur per grant.

Decomposition:
- Package rr_burst_arbiter_pkg holds:
  - state_e enum {IDLE, BURST};
  - the default parameter constants.
- One sub-module rr_priority_picker (parameter N) contains the combinational search logic.
  - Inputs: req[N] and ptr.
  - Outputs: one-hot winner[N], winner index, any.
  - Implementation: double-width rotate plus a find-first.
- Top level holds the FSM, beat counter, pointer and datapath mux.

Test Plan:
1. Reset then req=4'b0001, req_len[0]=3, out_ready=1, req_valid[0]=1 -> gnt=0001 one cycle after req; 4 beats, out_last on the 4th only; out_id=0; then IDLE.
2. req=4'b1111 held, all len=0 -> grants in order 0,1,2,3,0 each separated by one IDLE cycle; each grant lasts 1 beat.
3. Owner 2 with len=7, out_ready toggles 1/0 every cycle -> exactly 8 handshakes; cnt holds during stalls; req_ready[2]=out_ready; other req_ready stay 0.
4. Owner 1 drops req after beat 2 of a len=5 burst while req[3]=1 -> grant stays on 1 until its 6th beat; the next grant goes to 3.
5. rst asserted mid-burst (owner 2, 3 of 8 beats done) with req=4'b0110 held -> outputs 0 in the same cycle; after release, the first grant goes to 1, not 2.
6. req_len[0] changed from 2 to 9 on the cycle after the grant -> burst still ends after 3 beats.
